// File: rtl/dvc_bus_master_pkg.sv
// Shared codes for the serial debug bridge: dvc access codes, command bytes,
// FSM encoding and small command-decode helpers.
package dvc_bus_master_pkg;

    // dvc load/store access codes driven on mem_ctl
    localparam logic [3:0] DMEM_NOP = 4'h0;
    localparam logic [3:0] DMEM_LW  = 4'h1;
    localparam logic [3:0] DMEM_LBU = 4'h3;
    localparam logic [3:0] DMEM_SW  = 4'h8;
    localparam logic [3:0] DMEM_SB  = 4'h9;

    // host command / response bytes
    localparam logic [7:0] CMD_W  = 8'h57;  // 'W' word write
    localparam logic [7:0] CMD_B  = 8'h42;  // 'B' byte write
    localparam logic [7:0] CMD_R  = 8'h52;  // 'R' word read
    localparam logic [7:0] CMD_RB = 8'h62;  // 'b' byte read (zero-extended)
    localparam logic [7:0] ACK    = 8'h2E;  // '.'
    localparam logic [7:0] NAK    = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACCESS,
        ST_CAPT,
        ST_RESP,
        ST_TXLD,
        ST_TXGAP
    } state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == CMD_W) || (c == CMD_B) || (c == CMD_R) || (c == CMD_RB);
    endfunction

    function automatic logic cmd_is_write(input logic [7:0] c);
        return (c == CMD_W) || (c == CMD_B);
    endfunction

    // number of data bytes following the address (writes only)
    function automatic logic [2:0] cmd_data_bytes(input logic [7:0] c);
        return (c == CMD_W) ? 3'd4 : 3'd1;
    endfunction

    function automatic logic [3:0] cmd_dmem(input logic [7:0] c);
        logic [3:0] m;
        m = DMEM_NOP;
        case (c)
            CMD_W:   m = DMEM_SW;
            CMD_B:   m = DMEM_SB;
            CMD_R:   m = DMEM_LW;
            CMD_RB:  m = DMEM_LBU;
            default: m = DMEM_NOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dvc_bus_master.sv
// Serial debug bridge: turns a UART command stream into single dvc bus
// accesses and streams the response bytes back through the UART transmitter.
module dvc_bus_master
    import dvc_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_ft,
    output logic [7:0]  tx_data,
    output logic        tx_ld,
    input  logic        tx_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  mem_ctl,
    input  logic [31:0] bus_rdata,
    output logic        bus_busy
);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_cmd;
    logic [2:0]       r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_sh;
    logic [TO_W-1:0]  r_to;
    logic             r_rx_ft;
    logic             r_rx_skip;
    logic             r_tx_ld;
    logic [7:0]       r_tx_data;
    logic             r_busy;

    logic             w_rx_open;
    logic             w_rx_take;
    logic             w_in_frame;
    logic             w_to_hit;

    // the UART flag lags rx_ft by a cycle, so rx_rdy is not trusted until two
    // cycles after a capture
    assign w_rx_open  = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_rx_take  = w_rx_open && rx_rdy && !r_rx_ft && !r_rx_skip;
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_to_hit   = w_in_frame && (r_to == TO_W'(TIMEOUT));

    assign rx_ft     = r_rx_ft;
    assign tx_ld     = r_tx_ld;
    assign tx_data   = r_tx_data;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_busy  = r_busy;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // next-state and the single-cycle bus strobe
    always_comb begin
        w_next  = r_state;
        mem_ctl = DMEM_NOP;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_take) w_next = cmd_known(rx_data) ? ST_ADDR : ST_RESP;
            end
            ST_ADDR: begin
                if (w_to_hit)
                    w_next = ST_IDLE;
                else if (w_rx_take && r_cnt == 3'd3)
                    w_next = cmd_is_write(r_cmd) ? ST_DATA : ST_ACCESS;
            end
            ST_DATA: begin
                if (w_to_hit)
                    w_next = ST_IDLE;
                else if (w_rx_take && r_cnt == cmd_data_bytes(r_cmd) - 3'd1)
                    w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_ctl = cmd_dmem(r_cmd);
                w_next  = cmd_is_write(r_cmd) ? ST_RESP : ST_CAPT;
            end
            ST_CAPT:  w_next = ST_RESP;
            ST_RESP: begin
                if (!tx_busy) w_next = (r_cnt == 3'd0) ? ST_IDLE : ST_TXLD;
            end
            ST_TXLD:  w_next = ST_TXGAP;
            ST_TXGAP: w_next = ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    // datapath: byte shift-in, read capture, byte shift-out, handshakes, timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd     <= 8'h00;
            r_cnt     <= 3'd0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_sh      <= 32'h0;
            r_to      <= '0;
            r_rx_ft   <= 1'b0;
            r_rx_skip <= 1'b0;
            r_tx_ld   <= 1'b0;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_rx_ft   <= w_rx_take;
            r_rx_skip <= r_rx_ft;
            r_tx_ld   <= 1'b0;
            r_to      <= (w_in_frame && !w_rx_take && !w_to_hit) ? r_to + 1'b1 : '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_take) begin
                        r_cmd   <= rx_data;
                        r_busy  <= 1'b1;
                        r_wdata <= 32'h0;
                        r_cnt   <= 3'd0;
                        if (!cmd_known(rx_data)) begin
                            r_sh  <= {NAK, 24'h0};
                            r_cnt <= 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_to_hit) begin
                        r_busy <= 1'b0;
                    end else if (w_rx_take) begin
                        r_addr <= {r_addr[23:0], rx_data};
                        r_cnt  <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (w_to_hit) begin
                        r_busy <= 1'b0;
                    end else if (w_rx_take) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                ST_ACCESS: begin
                    if (cmd_is_write(r_cmd)) begin
                        r_sh  <= {ACK, 24'h0};
                        r_cnt <= 3'd1;
                    end
                end
                ST_CAPT: begin
                    // slave data is valid exactly one cycle after the access
                    if (r_cmd == CMD_R) begin
                        r_sh  <= bus_rdata;
                        r_cnt <= 3'd4;
                    end else begin
                        r_sh  <= {bus_rdata[7:0], 24'h0};
                        r_cnt <= 3'd1;
                    end
                end
                ST_RESP: begin
                    if (!tx_busy) begin
                        if (r_cnt == 3'd0) begin
                            r_busy <= 1'b0;
                        end else begin
                            r_tx_ld   <= 1'b1;
                            r_tx_data <= r_sh[31:24];
                            r_sh      <= {r_sh[23:0], 8'h00};
                            r_cnt     <= r_cnt - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
